// File: rtl/mem64_responder_if.sv
// ---------------------------------------------------------------------------
// mem64_responder_if
// Load/store bus between the multicycle control FSM (master) and the data
// memory responder (slave).
//   req_valid/req_ready : request handshake, one transfer per accept
//   req_write           : 1 = store, 0 = load
//   req_addr            : byte address
//   req_funct3          : RISC-V access size / extension code
//   req_wdata           : store data, right-aligned for sub-word stores
//   resp_valid          : one-cycle completion pulse
//   resp_rdata          : load result (0 for stores and errors)
//   resp_error          : request was misaligned, out of range or illegal
//   busy                : responder is not idle
// ---------------------------------------------------------------------------
interface mem64_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [2:0]  req_funct3;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_error;
    logic        busy;

    modport master (
        output req_valid, req_write, req_addr, req_funct3, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_funct3, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error, busy
    );
endinterface

// File: rtl/mem64_responder.sv
// ---------------------------------------------------------------------------
// mem64_responder
// Data-memory responder with a programmable access latency. One ld/sd-family
// request is accepted at a time; loads return sign/zero-extended data and
// sub-word stores are done as a byte-lane read-modify-write.
//   clk   : clock, rising edge
//   rst_n : synchronous reset, ACTIVE-HIGH despite the name
//   bus   : mem64_responder_if.slave (request/response signals)
// Parameters:
//   DEPTH_WORDS : number of 64-bit words (byte range 0 .. DEPTH_WORDS*8-1)
//   LATENCY     : wait cycles between accept and data access (>= 1)
// ---------------------------------------------------------------------------
module mem64_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    mem64_responder_if.slave   bus
);
    localparam int              AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int              CW       = $clog2(LATENCY + 1);
    localparam logic [60:0]     DEPTH_L  = 61'(DEPTH_WORDS);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COMMIT, S_RESP} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_cnt;
    logic            r_write;
    logic [2:0]      r_funct3;
    logic [2:0]      r_offset;
    logic [AW-1:0]   r_widx;
    logic [63:0]     r_wdata;
    logic [63:0]     r_rdata;
    logic            r_error;
    logic [63:0]     r_mem [DEPTH_WORDS];

    logic            w_accept;
    logic            w_misaligned;
    logic            w_illegal;
    logic [63:0]     w_word;
    logic [63:0]     w_shifted;
    logic [63:0]     w_load_data;
    logic [7:0]      w_lane_base;
    logic [7:0]      w_lane_en;
    logic [63:0]     w_wdata_sh;
    logic [63:0]     w_merged;

    assign w_accept = bus.req_valid && (r_state == S_IDLE);

    // Legality is judged on the live request so an illegal one can go
    // straight to RESP at the accept edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves a signal unassigned would infer a latch.
        w_misaligned = 1'b0;
        case (bus.req_funct3[1:0])
            2'b01:   w_misaligned = bus.req_addr[0];
            2'b10:   w_misaligned = |bus.req_addr[1:0];
            2'b11:   w_misaligned = |bus.req_addr[2:0];
            default: w_misaligned = 1'b0;
        endcase
        w_illegal = (bus.req_funct3 == 3'b111)
                 || (bus.req_write && bus.req_funct3[2])
                 || w_misaligned
                 || (bus.req_addr[63:3] >= DEPTH_L);
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next_state = w_illegal ? S_RESP : S_WAIT;
            S_WAIT:   if (r_cnt == '0) w_next_state = r_write ? S_COMMIT : S_RESP;
            S_COMMIT: w_next_state = S_RESP;
            S_RESP:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Read port shared by the load path and the store merge.
    assign w_word    = r_mem[r_widx];
    assign w_shifted = w_word >> {r_offset, 3'b000};

    always_comb begin
        case (r_funct3)
            3'b000:  w_load_data = {{56{w_shifted[7]}},  w_shifted[7:0]};
            3'b001:  w_load_data = {{48{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load_data = {{32{w_shifted[31]}}, w_shifted[31:0]};
            3'b100:  w_load_data = {56'd0, w_shifted[7:0]};
            3'b101:  w_load_data = {48'd0, w_shifted[15:0]};
            3'b110:  w_load_data = {32'd0, w_shifted[31:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    // Store data bytes 0..size-1 land on lanes offset..offset+size-1.
    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_lane_base = 8'h01;
            2'b01:   w_lane_base = 8'h03;
            2'b10:   w_lane_base = 8'h0F;
            default: w_lane_base = 8'hFF;
        endcase
        w_lane_en  = w_lane_base << r_offset;
        w_wdata_sh = r_wdata << {r_offset, 3'b000};
        for (int k = 0; k < 8; k++) begin
            w_merged[8*k +: 8] = w_lane_en[k] ? w_wdata_sh[8*k +: 8] : w_word[8*k +: 8];
        end
    end

    // rst_n is active-high here: 1 means reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_write  <= 1'b0;
            r_funct3 <= 3'b000;
            r_offset <= 3'b000;
            r_widx   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_error  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_write  <= bus.req_write;
                    r_funct3 <= bus.req_funct3;
                    r_offset <= bus.req_addr[2:0];
                    r_widx   <= bus.req_addr[AW+2:3];
                    r_wdata  <= bus.req_wdata;
                    r_cnt    <= CNT_LOAD;
                    r_error  <= w_illegal;
                    r_rdata  <= '0;
                end
                S_WAIT: begin
                    if (r_cnt != '0)
                        r_cnt <= r_cnt - 1'b1;
                    else if (!r_write)
                        r_rdata <= w_load_data;
                end
                S_RESP: begin
                    // Response fields are only non-zero while in RESP.
                    r_rdata <= '0;
                    r_error <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the array is deliberately not reset; contents survive rst_n and
    // a reset in COMMIT suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst_n && r_state == S_COMMIT)
            r_mem[r_widx] <= w_merged;
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_error = r_error;
endmodule

// File: doc/mem64_responder.md
Name: mem64_responder

Overview:
- Data-memory responder on the load/store interface driven by the multicycle control FSM.
- Accepts one ld/sd-family request at a time through a valid/ready handshake and waits a programmable number of cycles.
- Loads return sign- or zero-extended data; sub-word stores are applied as a byte-lane read-modify-write.
- Replaces the flat 64-bit memory so the control unit can wait on `resp_valid` instead of fixed state counts.

Parameters:
- DEPTH_WORDS, 256: number of 64-bit words in the internal array; the legal byte address range is 0 .. DEPTH_WORDS*8-1.
- LATENCY, 2: wait cycles between accept and data access. Minimum 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-high; asserted (1) means reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  64  byte address.
- req_funct3  in  3  RISC-V funct3: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
- req_wdata  in  64  store data; the low bytes are used for sub-word stores.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  64  load result; 0 for stores and errors.
- resp_error  out  1  valid with `resp_valid`; marks a misaligned, out-of-range or illegal request.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=1 at a clock edge):
  - state goes to IDLE; `req_ready`=1; `resp_valid`=0; `resp_rdata`=0; `resp_error`=0; `busy`=0; wait counter cleared.
  - Memory array contents are not altered.
  - Reset wins over every other event in the same cycle.
- States: IDLE, WAIT, COMMIT, RESP.
- Accept: occurs when `req_valid` & `req_ready` at an edge in IDLE. `req_write`, `req_addr`, `req_funct3` and `req_wdata` are latched. Inputs are ignored outside IDLE.
- Size: 1, 2, 4 or 8 bytes from `funct3[1:0]`.
- Illegal request if any of the following holds:
  - funct3=111;
  - store with funct3[2]=1;
  - address not a multiple of the size;
  - addr[63:3] >= DEPTH_WORDS.
- Transitions:
  - IDLE -> RESP on an accepted illegal request.
  - IDLE -> WAIT on an accepted legal request; counter loaded with LATENCY-1.
  - WAIT: counter decrements each cycle. At 0, a load goes to RESP and a store goes to COMMIT. The load word is read on the WAIT -> RESP edge.
  - COMMIT: the addressed word is read, byte lanes are merged and the word is written back in this single cycle; then go to RESP.
  - RESP: `resp_valid`=1 for exactly this cycle, `req_ready`=0; then return to IDLE. There is no response back-pressure.
- Latency, with accept at edge T:
  - load `resp_valid` high in cycle T+LATENCY+1;
  - store `resp_valid` high in cycle T+LATENCY+2;
  - error `resp_valid` high in cycle T+1.
  - The next accept is possible at the edge that ends RESP.
- Byte lanes: little-endian. Byte offset o = addr[2:0]; lane k = word bits [8k+7:8k].
  - Store writes lanes o .. o+size-1 from `req_wdata` bytes 0 .. size-1. Other lanes are preserved.
- Load extension: the selected bytes are right-aligned.
  - funct3 000/001/010 sign-extend from bit 7/15/31.
  - 100/101/110 zero-extend.
  - 011 returns the full word.
- Errors:
  - `resp_error`=1 and `resp_rdata`=0.
  - No memory write occurs.
- Outputs: `resp_rdata` and `resp_error` hold their value only during RESP and are 0 otherwise.
- Reset mid-operation: the pending transaction is discarded with no response. A store reset in WAIT or COMMIT is not written.

Test Plan:
- LATENCY=2. sd 0x10, data 0x1122334455667788, accepted at T -> `resp_valid` at T+4 with error 0. Then ld 0x10 accepted at U -> `resp_rdata` 0x1122334455667788 at U+3.
- After the above, loads:
  - lb 0x10 -> 0xFFFFFFFFFFFFFF88;
  - lbu 0x10 -> 0x88;
  - lh 0x16 -> 0x1122;
  - lw 0x14 -> 0x11223344;
  - lwu 0x10 -> 0x55667788.
- sb 0x13 with `req_wdata` 0x...AB, then ld 0x10 -> 0x11223344AB667788. sh 0x16 with 0xBEEF, then ld 0x10 -> 0xBEEF3344AB667788.
- lw 0x12, sh 0x11 and funct3=111 at 0x10 -> each gives `resp_valid` and `resp_error` at T+1 with rdata 0. A following ld 0x10 shows memory unchanged.
- ld at 0x800 (DEPTH_WORDS=256) -> error at T+1. `req_valid` held high through busy -> no second accept until after RESP.
- sd 0x20, data 0xCAFE, with rst_n pulsed in WAIT -> no `resp_valid` and outputs at reset values. A later ld 0x20 returns the prior content (store 0 first, expect 0).
